rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ writeback sources, e.g. ALU, load unit and mul/div.
- Round-robin arbitration with a ready/valid handshake per source; the winner is registered into a one-entry write stage that drives the register-file write port on the next cycle.
- Provides read-port forwarding of the staged write, so decode reads the value about to be written.
- Sits between execute/writeback and the register file.

---
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register-file write port. Sources are arbitrated
// round-robin and the winner is staged for one cycle. The staged write is
// forwarded to the decode read ports. Define WB_ARB_FIXED_PRIO_EN to use
// fixed lowest-index-wins priority instead of round-robin.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      HOLD,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic                      WRITE_EN,
  output logic [ADDR_W-1:0]         WRITE_ADDR,
  output logic [DATA_W-1:0]         WRITE_DATA,
  input  logic [ADDR_W-1:0]         RD_ADDR1,
  input  logic [ADDR_W-1:0]         RD_ADDR2,
  output logic                      FWD1_HIT,
  output logic [DATA_W-1:0]         FWD1_DATA,
  output logic                      FWD2_HIT,
  output logic [DATA_W-1:0]         FWD2_DATA
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic              write_en_q;
  logic              grant_any;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  int                pos;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  grant_idx;
`endif

  // Search candidate positions in priority order; the first valid one wins.
  always_comb begin
    REQ_READY  = '0;
    grant_any  = 1'b0;
    grant_addr = '0;
    grant_data = '0;
    pos        = 0;
`ifndef WB_ARB_FIXED_PRIO_EN
    grant_idx  = '0;
`endif
    if (!RST && !HOLD) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
        pos = k;
`else
        pos = (int'(last) + 1 + k) % NUM_REQ;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!grant_any && (i == pos) && REQ_VALID[i]) begin
            grant_any    = 1'b1;
            REQ_READY[i] = 1'b1;
            grant_addr   = REQ_ADDR[i*ADDR_W +: ADDR_W];
            grant_data   = REQ_DATA[i*DATA_W +: DATA_W];
`ifndef WB_ARB_FIXED_PRIO_EN
            grant_idx    = IDX_W'(i);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      write_en_q <= 1'b0;
      WRITE_ADDR <= '0;
      WRITE_DATA <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      last       <= IDX_W'(NUM_REQ - 1);
`endif
    end else if (grant_any) begin
      // x0 writes complete the handshake but never enable the write port
      write_en_q <= (grant_addr != '0);
      WRITE_ADDR <= grant_addr;
      WRITE_DATA <= grant_data;
`ifndef WB_ARB_FIXED_PRIO_EN
      last       <= grant_idx;
`endif
    end else begin
      write_en_q <= 1'b0;
    end
  end

  // A write staged when reset arrives is dropped rather than committed.
  assign WRITE_EN = write_en_q & ~RST;

  assign FWD1_HIT  = WRITE_EN && (WRITE_ADDR == RD_ADDR1) && (RD_ADDR1 != '0);
  assign FWD1_DATA = FWD1_HIT ? WRITE_DATA : '0;
  assign FWD2_HIT  = WRITE_EN && (WRITE_ADDR == RD_ADDR2) && (RD_ADDR2 != '0);
  assign FWD2_DATA = FWD2_HIT ? WRITE_DATA : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a grant model predicts REQ_READY, and a
// queue of predicted staged writes is checked against the write/forward ports.
module tb_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          HOLD = 1'b0;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N*AW-1:0] REQ_ADDR = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]    REQ_READY;
  logic            WRITE_EN;
  logic [AW-1:0]   WRITE_ADDR;
  logic [DW-1:0]   WRITE_DATA;
  logic [AW-1:0]   RD_ADDR1 = '0;
  logic [AW-1:0]   RD_ADDR2 = '0;
  logic            FWD1_HIT;
  logic [DW-1:0]   FWD1_DATA;
  logic            FWD2_HIT;
  logic [DW-1:0]   FWD2_DATA;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            sticky = 1'b0;
  bit            wrote9 = 1'b0;
  bit            wrote0 = 1'b0;

  always #5 CLK = ~CLK;

  rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .HOLD(HOLD),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY),
    .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
    .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
    .FWD1_HIT(FWD1_HIT), .FWD1_DATA(FWD1_DATA),
    .FWD2_HIT(FWD2_HIT), .FWD2_DATA(FWD2_DATA)
  );

  // Register-file side: record writes that actually commit.
  always @(posedge CLK) begin
    if (WRITE_EN && WRITE_ADDR == 5'd9) wrote9 <= 1'b1;
    if (WRITE_EN && WRITE_ADDR == 5'd0) wrote0 <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_grant(logic [N-1:0] v, int last);
    int idx;
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      idx = k;
      if (v[idx[1:0]]) return idx;
    end
`else
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (v[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    REQ_ADDR[i*AW +: AW] = a;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  // One clock: check at negedge, predict next staged write, advance.
  task automatic step();
    exp_t          e;
    exp_t          n;
    int            g;
    logic [N-1:0]  mg;
    logic          exp_en;
    logic          h1;
    logic          h2;
    @(negedge CLK);
    g  = (RST || HOLD) ? -1 : model_grant(REQ_VALID, m_last);
    mg = '0;
    if (g >= 0) mg[g[1:0]] = 1'b1;
    chk("req_ready", 32'(REQ_READY), 32'(mg));
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
      e = '{1'b0, '0, '0};
    end else begin
      e = q.pop_front();
    end
    exp_en = e.en && !RST;
    h1 = exp_en && (e.addr == RD_ADDR1) && (RD_ADDR1 != '0);
    h2 = exp_en && (e.addr == RD_ADDR2) && (RD_ADDR2 != '0);
    chk("write_en",   32'(WRITE_EN),   32'(exp_en));
    chk("write_addr", 32'(WRITE_ADDR), 32'(e.addr));
    chk("write_data", WRITE_DATA,      e.data);
    chk("fwd1_hit",   32'(FWD1_HIT),   32'(h1));
    chk("fwd1_data",  FWD1_DATA,       h1 ? e.data : 32'h0);
    chk("fwd2_hit",   32'(FWD2_HIT),   32'(h2));
    chk("fwd2_data",  FWD2_DATA,       h2 ? e.data : 32'h0);
    if (RST) begin
      n = '{1'b0, '0, '0};
      m_last = N - 1;
    end else if (g >= 0) begin
      n.addr = REQ_ADDR[g*AW +: AW];
      n.data = REQ_DATA[g*DW +: DW];
      n.en   = (n.addr != '0);
`ifndef WB_ARB_FIXED_PRIO_EN
      m_last = g;
`endif
    end else begin
      n = '{1'b0, m_addr, m_data};
    end
    m_addr = n.addr;
    m_data = n.data;
    q.push_back(n);
    @(posedge CLK);
    #1;
    if (g >= 0 && !sticky) REQ_VALID[g[1:0]] = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    m_last = N - 1;
    m_addr = '0;
    m_data = '0;
    q.push_back('{1'b0, '0, '0});

    // Requests present during reset must not be granted
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    REQ_VALID = 3'b111;
    step();

    // Round-robin 0,1,2 with each requester dropping after accept
    RST = 1'b0;
    repeat (4) step();

    // Forwarding of a staged write from requester 2
    RD_ADDR1 = 5'd7;
    RD_ADDR2 = 5'd6;
    set_req(2, 5'd7, 32'h55);
    REQ_VALID = 3'b100;
    repeat (2) step();

    // x0 write: handshake completes, no write enable, no forward hit
    RD_ADDR1 = 5'd0;
    set_req(1, 5'd0, 32'hFFFF_FFFF);
    REQ_VALID = 3'b010;
    repeat (2) step();

    // HOLD with all requesters continuously valid
    sticky = 1'b1;
    RD_ADDR1 = 5'd5;
    RD_ADDR2 = 5'd6;
    set_req(0, 5'd4, 32'h400);
    set_req(1, 5'd5, 32'h500);
    set_req(2, 5'd6, 32'h600);
    REQ_VALID = 3'b111;
    step();
    HOLD = 1'b1;
    repeat (4) step();
    HOLD = 1'b0;
    repeat (4) step();

    // Reset while a write to register 9 is staged
    sticky = 1'b0;
    REQ_VALID = 3'b000;
    step();
    set_req(0, 5'd9, 32'h99);
    REQ_VALID = 3'b001;
    step();
    RST = 1'b1;
    HOLD = 1'b1;
    REQ_VALID = 3'b111;
    step();
    chk("reg9_untouched", 32'(wrote9), 32'd0);
    RST = 1'b0;
    HOLD = 1'b0;
    set_req(0, 5'd10, 32'h1010);
    set_req(1, 5'd11, 32'h1111);
    set_req(2, 5'd12, 32'h1212);
    repeat (2) step();

    // Requesters 0 and 2 continuously valid
    sticky = 1'b1;
    RD_ADDR1 = 5'd12;
    REQ_VALID = 3'b101;
    repeat (6) step();
    sticky = 1'b0;
    REQ_VALID = 3'b000;
    repeat (2) step();

    chk("reg0_untouched", 32'(wrote0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
